// File: rtl/tx_frame_packer_if.sv
// Write-side and framed-output signals of tx_frame_packer, bundled so the
// packer and its feeder share one connection.
interface tx_frame_packer_if;
   logic       link_ready;
   logic       wr_en;
   logic [9:0] wr_data;
   logic       full;
   logic       overflow;
   logic       frame_abort;
   logic [9:0] DataIn;
   logic       DataInEn;
   logic       frame_done;

   modport master (
      output link_ready, wr_en, wr_data,
      input  full, overflow, frame_abort, DataIn, DataInEn, frame_done
   );

   modport slave (
      input  link_ready, wr_en, wr_data,
      output full, overflow, frame_abort, DataIn, DataInEn, frame_done
   );
endinterface

// File: rtl/tx_frame_packer.sv
// Buffers 10-bit samples in a FIFO and emits HEADER, LENGTH, payload, CHECKSUM
// frames on DataIn/DataInEn while the downstream link is ready.
module tx_frame_packer #(
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned AW        = 6,
   parameter int unsigned FRAME_LEN = 16,
   parameter logic [9:0]  HEADER    = 10'h303,
   parameter int unsigned GAP       = 2
) (
   input logic               CLK_10MHZ,
   input logic               nRst,
   tx_frame_packer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_LENGTH,
      S_PAYLOAD,
      S_CHECKSUM,
      S_GAP
   } state_t;

   localparam int unsigned CW       = AW + 1;
   localparam int unsigned GW       = (GAP > 2) ? $clog2(GAP - 1) : 1;
   localparam logic [AW:0] FULL_CNT = CW'(DEPTH);
   localparam logic [AW:0] FL_CNT   = CW'(FRAME_LEN);
   localparam logic [AW:0] FL_LAST  = CW'(FRAME_LEN - 1);
   localparam logic [9:0]  FL_WORD  = 10'(FRAME_LEN);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 1) ? GAP - 2 : 0);

   state_t          state, state_nxt;
   logic [9:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic [9:0]      acc, acc_nxt;
   logic [AW:0]     wcnt, wcnt_nxt;
   logic [GW-1:0]   gcnt, gcnt_nxt;
   logic [9:0]      data_q, data_nxt;
   logic            en_q, en_nxt;
   logic            done_q, done_nxt;
   logic            overflow_q, abort_q;
   logic            frame_active, abort, pop, wr_ok, full;
   logic [9:0]      rd_word;

   assign full         = (count == FULL_CNT);
   assign frame_active = state inside {S_HEADER, S_LENGTH, S_PAYLOAD, S_CHECKSUM};
   assign abort        = frame_active && !bus.link_ready;
   assign pop          = (state == S_PAYLOAD) && bus.link_ready;
   assign wr_ok        = bus.wr_en && !full && !abort;
   assign rd_word      = mem[rd_ptr];

   assign bus.full        = full;
   assign bus.overflow    = overflow_q;
   assign bus.frame_abort = abort_q;
   assign bus.DataIn      = data_q;
   assign bus.DataInEn    = en_q;
   assign bus.frame_done  = done_q;

   always_ff @(posedge CLK_10MHZ) begin
      if (wr_ok) mem[wr_ptr] <= bus.wr_data;
   end

   // An abort flushes by snapping the read pointer onto the write pointer.
   always_ff @(posedge CLK_10MHZ or negedge nRst) begin
      if (!nRst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else if (abort) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (bus.wr_en && full) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge CLK_10MHZ or negedge nRst) begin
      if (!nRst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // The IDLE cycle that re-checks the start condition serves as the last
   // gap cycle, so S_GAP itself lasts GAP-1 cycles.
   always_comb begin
      state_nxt = state;
      data_nxt  = '0;
      en_nxt    = 1'b0;
      done_nxt  = 1'b0;
      acc_nxt   = acc;
      wcnt_nxt  = wcnt;
      gcnt_nxt  = gcnt;
      case (state)
         S_IDLE: begin
            if (bus.link_ready && (count >= FL_CNT)) state_nxt = S_HEADER;
         end
         S_HEADER: begin
            data_nxt  = HEADER;
            en_nxt    = 1'b1;
            acc_nxt   = HEADER;
            state_nxt = S_LENGTH;
         end
         S_LENGTH: begin
            data_nxt  = FL_WORD;
            en_nxt    = 1'b1;
            acc_nxt   = acc + FL_WORD;
            wcnt_nxt  = '0;
            state_nxt = S_PAYLOAD;
         end
         S_PAYLOAD: begin
            data_nxt = rd_word;
            en_nxt   = 1'b1;
            acc_nxt  = acc + rd_word;
            if (wcnt == FL_LAST) state_nxt = S_CHECKSUM;
            else                 wcnt_nxt  = wcnt + CW'(1);
         end
         S_CHECKSUM: begin
            data_nxt  = acc;
            en_nxt    = 1'b1;
            done_nxt  = 1'b1;
            acc_nxt   = '0;
            gcnt_nxt  = '0;
            state_nxt = (GAP > 1) ? S_GAP : S_IDLE;
         end
         S_GAP: begin
            if (gcnt == GAP_LAST) state_nxt = S_IDLE;
            else                  gcnt_nxt  = gcnt + GW'(1);
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort) begin
         state_nxt = S_IDLE;
         data_nxt  = '0;
         en_nxt    = 1'b0;
         done_nxt  = 1'b0;
         acc_nxt   = '0;
      end
   end

   always_ff @(posedge CLK_10MHZ or negedge nRst) begin
      if (!nRst) begin
         data_q  <= '0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
         acc     <= '0;
         wcnt    <= '0;
         gcnt    <= '0;
         abort_q <= 1'b0;
      end else begin
         data_q <= data_nxt;
         en_q   <= en_nxt;
         done_q <= done_nxt;
         acc    <= acc_nxt;
         wcnt   <= wcnt_nxt;
         gcnt   <= gcnt_nxt;
         if (abort) abort_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tx_frame_packer.sv
// Self-checking bench for tx_frame_packer: a vector table for one full frame
// plus directed sequences for gaps, abort, overflow, reset and pointer wrap.
module tb_tx_frame_packer;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;
   localparam int unsigned FL    = 16;
   localparam int unsigned GAP   = 2;
   localparam logic [9:0]  HDR   = 10'h303;

   typedef struct {
      logic       link_ready;
      logic       wr_en;
      logic [9:0] wr_data;
      logic       exp_en;
      logic       exp_done;
      logic [9:0] exp_data;
   } vec_t;

   logic CLK_10MHZ = 1'b0;
   logic nRst;
   always #50 CLK_10MHZ = ~CLK_10MHZ;

   tx_frame_packer_if bus();

   tx_frame_packer #(
      .DEPTH(DEPTH), .AW(AW), .FRAME_LEN(FL), .HEADER(HDR), .GAP(GAP)
   ) dut (
      .CLK_10MHZ(CLK_10MHZ),
      .nRst(nRst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   logic        cap_on = 1'b0;
   logic [11:0] cap_q[$];
   logic [11:0] exp_q[$];
   logic [9:0]  model_q[$];

   always @(negedge CLK_10MHZ)
      if (cap_on) cap_q.push_back({bus.DataInEn, bus.frame_done, bus.DataIn});

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string msg);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, msg);
   endtask

   task automatic write_word(input logic [9:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      @(negedge CLK_10MHZ);
      bus.wr_en   = 1'b0;
   endtask

   task automatic add_frame();
      logic [9:0] sum;
      logic [9:0] w;
      sum = HDR;
      exp_q.push_back({2'b10, HDR});
      sum = sum + 10'(FL);
      exp_q.push_back({2'b10, 10'(FL)});
      for (int i = 0; i < int'(FL); i++) begin
         w   = model_q.pop_front();
         sum = sum + w;
         exp_q.push_back({2'b10, w});
      end
      exp_q.push_back({2'b11, sum});
   endtask

   task automatic compare_stream(input string name, input bit with_gaps);
      logic [11:0] got[$];
      int first;
      first = -1;
      if (with_gaps) begin
         foreach (cap_q[i]) if (first < 0 && cap_q[i][11]) first = i;
         if (first < 0) begin
            fail(name, "no DataInEn observed");
            return;
         end
         for (int i = first; i < cap_q.size() && got.size() < exp_q.size(); i++)
            got.push_back(cap_q[i]);
      end else begin
         foreach (cap_q[i]) if (cap_q[i][11]) got.push_back(cap_q[i]);
      end
      check({name, " length"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("%s word %0d", name, i), got[i], exp_q[i]);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[$];
      vec_t        v;
      logic [9:0]  d;
      int          n;
      int          nw;
      bit          found;
      logic        seen;

      nRst           = 1'b0;
      bus.link_ready = 1'b0;
      bus.wr_en      = 1'b0;
      bus.wr_data    = '0;
      repeat (2) @(negedge CLK_10MHZ);
      check("reset outputs", {bus.DataInEn, bus.frame_done, bus.DataIn}, 0);
      check("reset flags", {bus.full, bus.overflow, bus.frame_abort}, 0);
      nRst = 1'b1;

      // Buffer 1..16 with the link down: nothing may be sent.
      cap_q.delete();
      cap_on = 1'b1;
      for (int i = 1; i <= 16; i++) write_word(10'(i));
      @(negedge CLK_10MHZ);
      cap_on = 1'b0;
      n = 0;
      foreach (cap_q[i]) if (cap_q[i][11]) n++;
      check("idle while link down", n, 0);
      check("count after 16 writes", dut.count, 16);
      check("full after 16 writes", bus.full, 0);

      // One frame, cycle by cycle.
      v.link_ready = 1'b1; v.wr_en = 1'b0; v.wr_data = '0;
      v.exp_en = 1'b0; v.exp_done = 1'b0; v.exp_data = '0;
      vecs.push_back(v);
      v.exp_en = 1'b1; v.exp_data = 10'h303; vecs.push_back(v);
      v.exp_data = 10'h010; vecs.push_back(v);
      for (int i = 1; i <= 16; i++) begin
         v.exp_data = 10'(i);
         vecs.push_back(v);
      end
      v.exp_done = 1'b1; v.exp_data = 10'h39B; vecs.push_back(v);
      v.exp_en = 1'b0; v.exp_done = 1'b0; v.exp_data = '0;
      repeat (3) vecs.push_back(v);
      foreach (vecs[i]) begin
         bus.link_ready = vecs[i].link_ready;
         bus.wr_en      = vecs[i].wr_en;
         bus.wr_data    = vecs[i].wr_data;
         @(negedge CLK_10MHZ);
         check($sformatf("frame vec %0d", i), {bus.DataInEn, bus.frame_done, bus.DataIn},
               {vecs[i].exp_en, vecs[i].exp_done, vecs[i].exp_data});
      end
      bus.wr_en = 1'b0;

      // Two back-to-back frames from 32 buffered words, exact gap.
      bus.link_ready = 1'b0;
      model_q.delete();
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
         d = 10'(40 + i * 3);
         model_q.push_back(d);
         write_word(d);
      end
      add_frame();
      repeat (GAP) exp_q.push_back(12'h000);
      add_frame();
      repeat (5) exp_q.push_back(12'h000);
      cap_q.delete();
      cap_on = 1'b1;
      bus.link_ready = 1'b1;
      repeat (60) @(negedge CLK_10MHZ);
      cap_on = 1'b0;
      compare_stream("two frames", 1'b1);
      check("no abort after clean frames", bus.frame_abort, 0);

      // Drop the link after the 5th payload word, with a write in that cycle.
      bus.link_ready = 1'b0;
      for (int i = 0; i < 16; i++) write_word(10'(200 + i));
      bus.link_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge CLK_10MHZ);
         if (bus.DataInEn && bus.DataIn == 10'd204) found = 1'b1;
      end
      if (!found) fail("abort setup", "5th payload word never seen");
      bus.link_ready = 1'b0;
      bus.wr_en      = 1'b1;
      bus.wr_data    = 10'h155;
      @(negedge CLK_10MHZ);
      bus.wr_en = 1'b0;
      check("abort outputs", {bus.DataInEn, bus.frame_done}, 0);
      check("abort flag", bus.frame_abort, 1);
      check("abort flush count", dut.count, 0);
      check("abort no overflow", bus.overflow, 0);
      seen = 1'b0;
      repeat (5) begin
         @(negedge CLK_10MHZ);
         seen = seen | bus.DataInEn | bus.frame_done;
      end
      check("quiet after abort", seen, 0);

      // Overfill: 65 writes into an empty FIFO with the link down.
      for (int i = 0; i < 64; i++) begin
         write_word(10'(500 + i));
         if (i == 62) check("full after 63 writes", bus.full, 0);
      end
      check("full after 64 writes", bus.full, 1);
      check("no overflow at 64", bus.overflow, 0);
      write_word(10'h3AA);
      check("overflow on 65th", bus.overflow, 1);
      check("count stays 64", dut.count, 64);
      repeat (3) @(negedge CLK_10MHZ);
      check("overflow sticky", bus.overflow, 1);

      // Async reset in the middle of a frame.
      bus.link_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge CLK_10MHZ);
         if (bus.DataInEn) found = 1'b1;
      end
      if (!found) fail("reset setup", "frame never started");
      #20;
      nRst = 1'b0;
      #1;
      check("async reset outputs",
            {bus.DataInEn, bus.frame_done, bus.DataIn, bus.full, bus.overflow, bus.frame_abort}, 0);
      check("async reset count", dut.count, 0);
      @(negedge CLK_10MHZ);
      nRst = 1'b1;
      bus.link_ready = 1'b0;

      // Full FIFO, then keep writing (respecting full) while frames drain.
      model_q.delete();
      exp_q.delete();
      cap_q.delete();
      for (int i = 0; i < 64; i++) begin
         d = 10'(i * 7 + 3);
         model_q.push_back(d);
         write_word(d);
      end
      check("preload full", bus.full, 1);
      cap_on = 1'b1;
      bus.link_ready = 1'b1;
      nw = 64;
      for (int c = 0; c < 400 && nw < 144; c++) begin
         if (!bus.full) begin
            d = 10'(nw * 7 + 3);
            bus.wr_en   = 1'b1;
            bus.wr_data = d;
            model_q.push_back(d);
            nw++;
         end else begin
            bus.wr_en = 1'b0;
         end
         @(negedge CLK_10MHZ);
      end
      bus.wr_en = 1'b0;
      check("streaming writes accepted", nw, 144);
      repeat (120) @(negedge CLK_10MHZ);
      cap_on = 1'b0;
      repeat (9) add_frame();
      compare_stream("streaming", 1'b0);
      check("streaming no overflow", bus.overflow, 0);
      check("streaming no abort", bus.frame_abort, 0);
      check("streaming drained", dut.count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
